// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared defaults, state type and helpers for the alu_* blocks
package alu_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int NREG_DEFAULT = 32;

  // Register file sequencer: zero every entry first, then serve traffic
  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  // Address width for a power-of-two register count
  function automatic int addr_width(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

endpackage

// File: rtl/regfile_mem.sv
// rtl/regfile_mem.sv - register storage, one write port, two asynchronous read ports
module regfile_mem
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int NREG = NREG_DEFAULT,
  parameter int AW   = addr_width(NREG)
) (
  input  logic            clk,
  input  logic            clear_sel,
  input  logic [AW-1:0]   clear_addr,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] mem [NREG];

  logic            we;
  logic [AW-1:0]   waddr;
  logic [XLEN-1:0] wdata;

  // Write source select: the clear sequencer owns the port while it runs
  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    if (clear_sel) begin
      we    = 1'b1;
      waddr = clear_addr;
      wdata = '0;
    end else begin
      we    = wr_en;
      waddr = wr_addr;
      wdata = wr_data;
    end
  end

  // Storage update; entry 0 is the hardwired zero and is never written
  always_ff @(posedge clk) begin
    if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];

endmodule

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - ALU register file with bypass, x0 masking and post-reset clear
module alu_regfile
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int NREG = NREG_DEFAULT,
  localparam int AW  = addr_width(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] rs2,
  input  logic            rd_we,
  input  logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] rd,
  output logic            busy
);

  localparam logic [AW-1:0] LAST_REG = AW'(NREG - 1);

  state_t          state;
  logic [AW-1:0]   clr_cnt;
  logic [XLEN-1:0] mem_rdata1;
  logic [XLEN-1:0] mem_rdata2;
  logic            wr_ok;
  logic            byp1;
  logic            byp2;
  logic [XLEN-1:0] rs1_next;
  logic [XLEN-1:0] rs2_next;
  logic            clear_sel;
  logic            mem_wr_en;

  // Reset freezes the array; while clearing, the clear path owns the write port
  assign clear_sel = (state == CLEAR) && !rst;
  assign wr_ok     = rd_we && (rd_addr != '0);
  assign mem_wr_en = wr_ok && (state == READY) && !rst;

  regfile_mem #(
    .XLEN (XLEN),
    .NREG (NREG),
    .AW   (AW)
  ) u_mem (
    .clk        (clk),
    .clear_sel  (clear_sel),
    .clear_addr (clr_cnt),
    .wr_en      (mem_wr_en),
    .wr_addr    (rd_addr),
    .wr_data    (rd),
    .raddr1     (rs1_addr),
    .raddr2     (rs2_addr),
    .rdata1     (mem_rdata1),
    .rdata2     (mem_rdata2)
  );

  // Read data selection: x0 reads zero, a same-cycle write forwards new data
  always_comb begin
    byp1     = wr_ok && (rd_addr == rs1_addr);
    byp2     = wr_ok && (rd_addr == rs2_addr);
    rs1_next = '0;
    rs2_next = '0;
    if (rs1_addr != '0) begin
      rs1_next = byp1 ? rd : mem_rdata1;
    end
    if (rs2_addr != '0) begin
      rs2_next = byp2 ? rd : mem_rdata2;
    end
  end

  // Sequencer FSM with registered read outputs and busy flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= AW'(1);
      rs1     <= '0;
      rs2     <= '0;
      busy    <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          rs1     <= '0;
          rs2     <= '0;
          clr_cnt <= clr_cnt + AW'(1);
          if (clr_cnt == LAST_REG) begin
            state <= READY;
            busy  <= 1'b0;
          end
        end
        READY: begin
          rs1  <= rs1_next;
          rs2  <= rs2_next;
          busy <= 1'b0;
        end
        default: begin
          state <= CLEAR;
          busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_regfile.sv
// tb/tb_alu_regfile.sv - self-checking bench for alu_regfile
module tb_alu_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        rd_we = 1'b0;
  logic [4:0]  rd_addr = '0;
  logic [31:0] rd = '0;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  typedef struct {
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  vec_t vecs [12];
  exp_t sb [$];

  alu_regfile #(.XLEN(32), .NREG(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1      (rs1),
    .rs2      (rs2),
    .rd_we    (rd_we),
    .rd_addr  (rd_addr),
    .rd       (rd),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time exceeded, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: drive, push expectation, clock, pop and compare
  task automatic step(input string name, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2,
                      input logic [31:0] e1, input logic [31:0] e2);
    exp_t e;
    rd_we    = we;
    rd_addr  = wa;
    rd       = wd;
    rs1_addr = a1;
    rs2_addr = a2;
    e.e1 = e1;
    e.e2 = e2;
    sb.push_back(e);
    @(posedge clk);
    #1;
    rd_we = 1'b0;
    e = sb.pop_front();
    check({name, ".rs1"}, rs1, e.e1);
    check({name, ".rs2"}, rs2, e.e2);
  endtask

  task automatic do_reset();
    rd_we = 1'b0;
    rst   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset.rs1", rs1, 32'h0);
    check("reset.rs2", rs2, 32'h0);
    check("reset.busy", {31'b0, busy}, 32'h1);
    rst = 1'b0;
  endtask

  // Counts cycles with busy high, optionally stopping early and injecting a write
  task automatic count_busy(input int stop_at, input int wr_at, output int n);
    n = 0;
    while (busy && n < stop_at) begin
      if (n == wr_at) begin
        rd_we   = 1'b1;
        rd_addr = 5'd2;
        rd      = 32'h0000_1234;
      end
      @(posedge clk);
      #1;
      rd_we = 1'b0;
      n++;
    end
  endtask

  int n;
  logic [31:0] sum;

  initial begin
    vecs[0]  = '{1'b1, 5'd5,  32'h0000_000A, 5'd0,  5'd0,  32'h0,          32'h0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,         5'd5,  5'd0,  32'h0000_000A,  32'h0};
    vecs[2]  = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd0,  32'h0,          32'h0};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,         5'd0,  5'd0,  32'h0,          32'h0};
    vecs[4]  = '{1'b1, 5'd7,  32'd10,        5'd5,  5'd5,  32'h0000_000A,  32'h0000_000A};
    vecs[5]  = '{1'b1, 5'd7,  32'd21,        5'd7,  5'd7,  32'd21,         32'd21};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,         5'd7,  5'd5,  32'd21,         32'h0000_000A};
    vecs[7]  = '{1'b1, 5'd1,  32'hFFFF_FFFF, 5'd0,  5'd0,  32'h0,          32'h0};
    vecs[8]  = '{1'b1, 5'd2,  32'd2,         5'd1,  5'd0,  32'hFFFF_FFFF,  32'h0};
    vecs[9]  = '{1'b1, 5'd9,  32'h55,        5'd9,  5'd31, 32'h55,         32'h0};
    vecs[10] = '{1'b1, 5'd31, 32'hDEAD_BEEF, 5'd31, 5'd9,  32'hDEAD_BEEF,  32'h55};
    vecs[11] = '{1'b0, 5'd0,  32'h0,         5'd1,  5'd2,  32'hFFFF_FFFF,  32'd2};

    // Reset release and clear length
    do_reset();
    count_busy(100, -1, n);
    check("clear_len.initial", n, 32'd31);
    check("busy_low.initial", {31'b0, busy}, 32'h0);
    for (int i = 0; i < 32; i++) begin
      step("zero_after_clear", 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 32'h0, 32'h0);
    end

    // Table-driven write, read, x0 and bypass vectors
    for (int i = 0; i < 12; i++) begin
      step($sformatf("vec%0d", i), vecs[i].we, vecs[i].wa, vecs[i].wd,
           vecs[i].a1, vecs[i].a2, vecs[i].e1, vecs[i].e2);
    end

    // ALU round trip: x1 + x2 written back to x3 wraps to 1
    sum = rs1 + rs2;
    step("roundtrip.wr", 1'b1, 5'd3, sum, 5'd0, 5'd0, 32'h0, 32'h0);
    step("roundtrip.rd", 1'b0, 5'd0, 32'h0, 5'd3, 5'd0, 32'h0000_0001, 32'h0);

    // Reset mid-clear at cycle 10, then a write lost while busy
    do_reset();
    count_busy(10, -1, n);
    check("midclear.cycles_before_rst", n, 32'd10);
    check("midclear.still_busy", {31'b0, busy}, 32'h1);
    do_reset();
    count_busy(100, 9, n);
    check("clear_len.midclear", n, 32'd31);
    step("busy_write_lost", 1'b0, 5'd0, 32'h0, 5'd2, 5'd31, 32'h0, 32'h0);

    // Reset in READY after writing x5
    step("ready.wr_x5", 1'b1, 5'd5, 32'h0000_000A, 5'd0, 5'd0, 32'h0, 32'h0);
    step("ready.rd_x5", 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 32'h0000_000A, 32'h0000_000A);
    do_reset();
    count_busy(100, -1, n);
    check("clear_len.ready", n, 32'd31);
    step("ready.x5_zeroed", 1'b0, 5'd0, 32'h0, 5'd5, 5'd7, 32'h0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
